// File: rtl/mlp_argmax_classifier.sv
// Argmax over the final layer's FP32 scores using raw-bit compares; result after N_CLASSES edges, sticky until prev_layer_end drops.
// No backpressure: upstream holds scores while prev_layer_end=1. Define ARGMAX_TOP2_EN to also report the runner-up.
module mlp_argmax_classifier #(
    parameter int N_CLASSES = 10,
    parameter int IDX_W     = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [31:0]      scores [0:N_CLASSES-1],
    input  logic             prev_layer_end,
    output logic [IDX_W-1:0] class_idx,
    output logic [31:0]      max_value,
    output logic             result_valid,
    output logic             busy
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [IDX_W-1:0] second_idx,
    output logic [31:0]      second_value
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(N_CLASSES - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [31:0]      best;
    logic [IDX_W-1:0] best_idx;
    logic [31:0]      cand;
    logic [31:0]      nxt_best;
    logic [IDX_W-1:0] nxt_best_idx;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Sign-magnitude ordering on raw bits; strict greater-than so ties keep the lower index.
    function automatic logic wins(input logic [31:0] c, input logic [31:0] b);
        logic r;
        r = 1'b0;
        if (is_nan(c))
            r = 1'b0;
        else if (is_nan(b))
            r = 1'b1;
        else if ((c[30:0] == 31'd0) && (b[30:0] == 31'd0))
            r = 1'b0;
        else if (c[31] != b[31])
            r = ~c[31];
        else if (!c[31])
            r = (c[30:0] > b[30:0]);
        else
            r = (c[30:0] < b[30:0]);
        return r;
    endfunction

    always_comb begin
        cand = scores[0];
        for (int i = 0; i < N_CLASSES; i++)
            if (ptr == IDX_W'(i))
                cand = scores[i];
    end

`ifdef ARGMAX_TOP2_EN
    logic [31:0]      second;
    logic [IDX_W-1:0] second_i;
    logic             second_full;
    logic [31:0]      nxt_second;
    logic [IDX_W-1:0] nxt_second_i;
`endif

    always_comb begin
        nxt_best     = best;
        nxt_best_idx = best_idx;
`ifdef ARGMAX_TOP2_EN
        nxt_second   = second;
        nxt_second_i = second_i;
`endif
        if (wins(cand, best)) begin
            nxt_best     = cand;
            nxt_best_idx = ptr;
`ifdef ARGMAX_TOP2_EN
            nxt_second   = best;
            nxt_second_i = best_idx;
        end else if (!second_full || wins(cand, second)) begin
            nxt_second   = cand;
            nxt_second_i = ptr;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            best         <= '0;
            best_idx     <= '0;
            class_idx    <= '0;
            max_value    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            second       <= '0;
            second_i     <= '0;
            second_full  <= 1'b0;
            second_idx   <= '0;
            second_value <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (prev_layer_end) begin
                    best     <= scores[0];
                    best_idx <= '0;
                    ptr      <= IDX_W'(1);
`ifdef ARGMAX_TOP2_EN
                    second      <= '0;
                    second_i    <= '0;
                    second_full <= 1'b0;
`endif
                    if (N_CLASSES == 1) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        class_idx    <= '0;
                        max_value    <= scores[0];
`ifdef ARGMAX_TOP2_EN
                        second_idx   <= '0;
                        second_value <= '0;
`endif
                    end else begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: if (!prev_layer_end) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    best     <= nxt_best;
                    best_idx <= nxt_best_idx;
                    ptr      <= ptr + IDX_W'(1);
`ifdef ARGMAX_TOP2_EN
                    second      <= nxt_second;
                    second_i    <= nxt_second_i;
                    second_full <= 1'b1;
`endif
                    if (ptr == LAST_PTR) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        class_idx    <= nxt_best_idx;
                        max_value    <= nxt_best;
`ifdef ARGMAX_TOP2_EN
                        second_idx   <= nxt_second_i;
                        second_value <= nxt_second;
`endif
                    end
                end
                DONE: if (!prev_layer_end) begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_argmax_classifier.sv
// Directed bench: a 4-class and a 1-class instance, expectations queued per scan and popped when result_valid rises.
module tb_mlp_argmax_classifier;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] s4 [0:3];
    logic [31:0] s1 [0:0];
    logic        ple4, ple1;
    logic [1:0]  idx4;
    logic [0:0]  idx1;
    logic [31:0] val4, val1;
    logic        rv4, rv1, busy4, busy1;
`ifdef ARGMAX_TOP2_EN
    logic [1:0]  sidx4;
    logic [0:0]  sidx1;
    logic [31:0] sval4, sval1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] val;
        logic [31:0] sidx;
        logic [31:0] sval;
        bit          chk2;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    mlp_argmax_classifier #(.N_CLASSES(4), .IDX_W(2)) dut4 (
        .CLK(CLK), .reset(reset), .scores(s4), .prev_layer_end(ple4),
        .class_idx(idx4), .max_value(val4), .result_valid(rv4), .busy(busy4)
`ifdef ARGMAX_TOP2_EN
        , .second_idx(sidx4), .second_value(sval4)
`endif
    );

    mlp_argmax_classifier #(.N_CLASSES(1), .IDX_W(1)) dut1 (
        .CLK(CLK), .reset(reset), .scores(s1), .prev_layer_end(ple1),
        .class_idx(idx1), .max_value(val1), .result_valid(rv1), .busy(busy1)
`ifdef ARGMAX_TOP2_EN
        , .second_idx(sidx1), .second_value(sval1)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] idx, input logic [31:0] val,
                        input logic [31:0] sidx, input logic [31:0] sval, input bit chk2);
        exp_t e;
        e.idx = idx; e.val = val; e.sidx = sidx; e.sval = sval; e.chk2 = chk2;
        sb.push_back(e);
    endtask

    // Starts a scan on dut4, waits (bounded) for result_valid, then holds and releases prev_layer_end.
    task automatic run4(input string tag, input int hold);
        int   cyc;
        bit   got;
        exp_t e;
        logic [31:0] held_idx;
        ple4 = 1'b1;
        cyc = 0;
        got = 0;
        while (cyc < 12 && !got) begin
            tick();
            cyc++;
            if (cyc == 1) check({tag, "_busy"}, 32'(busy4), 32'd1);
            if (rv4) got = 1;
        end
        check({tag, "_latency"}, cyc, 4);
        e = sb.pop_front();
        check({tag, "_idx"}, 32'(idx4), e.idx);
        check({tag, "_val"}, val4, e.val);
`ifdef ARGMAX_TOP2_EN
        if (e.chk2) begin
            check({tag, "_sidx"}, 32'(sidx4), e.sidx);
            check({tag, "_sval"}, sval4, e.sval);
        end
`endif
        held_idx = 32'(idx4);
        for (int i = 0; i < hold; i++) begin
            tick();
            if (busy4 !== 1'b0 || rv4 !== 1'b1) check({tag, "_hold_stable"}, {30'd0, busy4, rv4}, 32'd1);
        end
        check({tag, "_hold_rv"}, 32'(rv4), 32'd1);
        check({tag, "_hold_val"}, val4, e.val);
        ple4 = 1'b0;
        tick();
        check({tag, "_release_rv"}, 32'(rv4), 32'd0);
        check({tag, "_release_idx"}, 32'(idx4), held_idx);
    endtask

    initial begin
        reset = 1'b1;
        ple4  = 1'b0;
        ple1  = 1'b0;
        s4    = '{32'h0, 32'h0, 32'h0, 32'h0};
        s1    = '{32'h0};
        tick();
        tick();
        check("rst_idx", 32'(idx4), 32'd0);
        check("rst_val", val4, 32'd0);
        check("rst_rv", 32'(rv4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        reset = 1'b0;
        tick();

        s4 = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000};
        push(1, 32'h40000000, 0, 32'h3F800000, 1);
        run4("basic", 2);

        s4 = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'hBF800000};
        push(2, 32'h80000000, 0, 32'hBF800000, 1);
        run4("negative", 2);

        s4 = '{32'h7FC00000, 32'h40000000, 32'h40000000, 32'h3F800000};
        push(1, 32'h40000000, 2, 32'h40000000, 1);
        run4("nan_tie", 2);

        s4 = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'h7FC00000};
        push(0, 32'h7F800000, 1, 32'h7F7FFFFF, 1);
        run4("inf", 2);

        s4 = '{32'h00000000, 32'h80000000, 32'h00000001, 32'hBF800000};
        push(2, 32'h00000001, 0, 32'h00000000, 1);
        run4("zeros", 2);

        s4 = '{32'h7FC00001, 32'hFFC00000, 32'h7F800001, 32'h7FFFFFFF};
        push(0, 32'h7FC00001, 0, 32'h0, 0);
        run4("all_nan", 20);

        // Abort two cycles into a scan, then a full rescan.
        s4 = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000};
        ple4 = 1'b1;
        tick();
        tick();
        check("abort_busy_pre", 32'(busy4), 32'd1);
        ple4 = 1'b0;
        tick();
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_rv", 32'(rv4), 32'd0);
        check("abort_idx", 32'(idx4), 32'd0);
        check("abort_val", val4, 32'h7FC00001);
        tick();
        push(1, 32'h40000000, 0, 32'h3F800000, 1);
        run4("rescan", 2);

        // Reset in the middle of a scan.
        s4 = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'hBF800000};
        ple4 = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        ple4  = 1'b0;
        tick();
        check("midrst_idx", 32'(idx4), 32'd0);
        check("midrst_val", val4, 32'd0);
        check("midrst_rv", 32'(rv4), 32'd0);
        check("midrst_busy", 32'(busy4), 32'd0);
        reset = 1'b0;
        tick();

        // Single-class instance.
        s1 = '{32'hC0000000};
        ple1 = 1'b1;
        tick();
        check("n1_rv", 32'(rv1), 32'd1);
        check("n1_idx", 32'(idx1), 32'd0);
        check("n1_val", val1, 32'hC0000000);
        check("n1_busy", 32'(busy1), 32'd0);
`ifdef ARGMAX_TOP2_EN
        check("n1_sidx", 32'(sidx1), 32'd0);
        check("n1_sval", sval1, 32'd0);
`endif
        ple1 = 1'b0;
        tick();
        check("n1_release_rv", 32'(rv1), 32'd0);
        check("n1_release_val", val1, 32'hC0000000);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
